hdlc_rx_monitor: RTL and testbench
==================================

HDLC_RX_MONITOR -- requirements
Module: hdlc_rx_monitor

Interface
REQ-001 Parameter CHANNELS, default 1: number of independent HDLC Rx lanes monitored, range 1..8.
REQ-002 Parameter FLAG_LATENCY, default 2: cycles from the last flag bit to the expected Rx_FlagDetect, range 1..7.
REQ-003 Parameter ERR_CNT_W, default 16: width of the error counter.
REQ-004 Clk  in  1  single clock; all logic is on the rising edge.
REQ-005 Rst  in  1  asynchronous, active-high reset.
REQ-006 Rx  in  CHANNELS  serial Rx bit per lane, one bit per cycle.
REQ-007 Rx_FlagDetect  in  CHANNELS  DUT flag-detect strobe per lane.
REQ-008 Rx_AbortDetect  in  CHANNELS  DUT abort-detect strobe per lane.
REQ-009 Rx_ValidFrame  in  CHANNELS  DUT valid-frame level per lane.
REQ-010 Rx_AbortSignal  in  CHANNELS  DUT abort-signal level per lane.
REQ-011 ErrClr  in  1  synchronous clear of ErrCnt.
REQ-012 ChState  out  2*CHANNELS  per-lane monitor state; lane i occupies bits [2i+1:2i].
REQ-013 Err_Flag  out  CHANNELS  one-cycle pulse: a missing (or spurious) Rx_FlagDetect.
REQ-014 Err_Abort  out  CHANNELS  one-cycle pulse: a missing Rx_AbortSignal.
REQ-015 FrameCnt  out  8*CHANNELS  per-lane count of closed frames, wraps at 255.
REQ-016 ErrCnt  out  ERR_CNT_W  total error count, saturating.

Function
REQ-017 Each lane SHALL hold an 8-bit shift register sr <= {sr[6:0], Rx[i]} and a 4-bit fill counter that saturates at 8.
REQ-018 Pattern detection in a lane SHALL be suppressed until its fill counter reaches 8.
REQ-019 Flag SHALL be detected when sr == 8'h7E; abort when sr == 8'h7F; idle when sr == 8'hFF.
REQ-020 Lane states SHALL be HUNT=0, IDLE=1, FRAME=2; the encoding 3 SHALL never occur.
REQ-021 Transitions: any state + flag -> FRAME; any state + abort -> HUNT; HUNT/FRAME + idle -> IDLE; otherwise hold.
REQ-022 A flag detected while in FRAME SHALL close the frame and increment FrameCnt for that lane.
REQ-023 A flag detected at cycle t SHALL be checked at cycle t+FLAG_LATENCY: Rx_FlagDetect[i] low at that cycle -> Err_Flag[i] pulses at t+FLAG_LATENCY+1.
REQ-024 Expected flags SHALL travel in a FLAG_LATENCY-deep delay line, so back-to-back flags (7E7E...) are each checked independently.
REQ-025 Rx_ValidFrame[i] && Rx_AbortDetect[i] at cycle t with Rx_AbortSignal[i] low at t+1 -> Err_Abort[i] pulses at t+2.
REQ-026 Each cycle, ErrCnt SHALL add the popcount of all Err_Flag and Err_Abort bits and saturate at 2^ERR_CNT_W-1.
REQ-027 ErrClr SHALL load ErrCnt with that cycle's popcount, so errors arriving with a clear are not lost.
REQ-028 Lanes SHALL be fully independent; simultaneous errors on all lanes in one cycle SHALL all be counted.

Reset
REQ-029 On Rst, every lane SHALL set sr=8'hFF, fill counter=0, delay line=0 and state=HUNT.
REQ-030 On Rst, FrameCnt, ErrCnt, Err_Flag and Err_Abort SHALL all be 0.
REQ-031 Rst asserted mid-frame SHALL discard pending checks, and no error pulse from before reset SHALL appear after release.

Configuration
REQ-032 With HDLC_MON_STRICT_EN defined, Rx_FlagDetect[i] high at a cycle with no expected flag due SHALL also pulse Err_Flag[i], one cycle later.
REQ-033 With HDLC_MON_STRICT_EN undefined, only missing flag detects SHALL be errors, and spurious strobes SHALL be ignored.

Structure
REQ-034 Package hdlc_mon_pkg SHALL hold the state enum and the constants FLAG=8'h7E, ABORT=8'h7F and IDLE=8'hFF.
REQ-035 Per-lane logic (shift register, fill counter, FSM, delay line, FrameCnt, error pulses) SHALL live in sub-module hdlc_mon_chan.
REQ-036 The top level SHALL instantiate hdlc_mon_chan CHANNELS times in a generate loop and own the popcount and ErrCnt.

Verification
REQ-037 Scenario: idle (8 ones) then bits 0111_1110, with Rx_FlagDetect high 2 cycles after the last 0 -> ChState=FRAME, Err_Flag=0, ErrCnt=0.
REQ-038 Scenario: same flag with Rx_FlagDetect held low -> Err_Flag pulses once at t+3, ErrCnt=1.
REQ-039 Scenario: flag, 16 data bits, closing flag -> FrameCnt=1; then 0111_1111 -> ChState=HUNT.
REQ-040 Scenario: Rx_ValidFrame=1 and Rx_AbortDetect=1 with Rx_AbortSignal=0 at the next cycle -> Err_Abort pulses at t+2, ErrCnt increments by 1.
REQ-041 Scenario: CHANNELS=4, all lanes miss a flag detect in the same cycle -> ErrCnt +4; ERR_CNT_W=2 variant saturates at 3.
REQ-042 Scenario: Rst pulsed one cycle before a due check -> no Err_Flag pulse; then 7 ones and a 0 after reset -> no false flag.

Source files
------------

// File: rtl/hdlc_mon_pkg.sv
// Shared lane-state encoding, HDLC octet patterns and next-state helper for the Rx monitor.
package hdlc_mon_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } chState_t;

    localparam logic [7:0] FLAG  = 8'h7E;
    localparam logic [7:0] ABORT = 8'h7F;
    localparam logic [7:0] IDLE  = 8'hFF;

    localparam logic [3:0] FILL_FULL = 4'd8;

    // The three patterns are mutually exclusive, so priority only matters for readability.
    function automatic chState_t nextState(
        input chState_t cur,
        input logic     isFlag,
        input logic     isAbort,
        input logic     isIdle
    );
        chState_t nxt;
        nxt = cur;
        if (isFlag) begin
            nxt = ST_FRAME;
        end else if (isAbort) begin
            nxt = ST_HUNT;
        end else if (isIdle && (cur != ST_IDLE)) begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hdlc_mon_chan.sv
// One monitored HDLC Rx lane: octet window, state tracking, frame count and error pulses.
// HDLC_MON_STRICT_EN additionally flags Rx_FlagDetect strobes that arrive with no flag due.
module hdlc_mon_chan
    import hdlc_mon_pkg::*;
#(
    parameter int FLAG_LATENCY = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       Rx_FlagDetect,
    input  logic       Rx_AbortDetect,
    input  logic       Rx_ValidFrame,
    input  logic       Rx_AbortSignal,
    output logic [1:0] ChState,
    output logic       Err_Flag,
    output logic       Err_Abort,
    output logic [7:0] FrameCnt
);

    logic [7:0]              sr_p0;
    logic [3:0]              fill_p0;
    chState_t                state_p0;
    logic [FLAG_LATENCY-1:0] flagVld_p;
    logic                    abortVld_p1;

    logic [7:0] srNext;
    logic [3:0] fillNext;
    logic       armed;
    logic       isFlag;
    logic       isAbort;
    logic       isIdle;
    logic       flagDue;
    logic       flagErr;
    logic       abortErr;

    // Detection looks at the window including the bit on Rx this cycle, so a flag
    // is "detected" in the cycle its last bit is presented.
    always_comb begin
        srNext   = {sr_p0[6:0], Rx};
        fillNext = (fill_p0 == FILL_FULL) ? FILL_FULL : fill_p0 + 4'd1;
        armed    = (fillNext == FILL_FULL);
        isFlag   = armed && (srNext == FLAG);
        isAbort  = armed && (srNext == ABORT);
        isIdle   = armed && (srNext == IDLE);
        flagDue  = flagVld_p[FLAG_LATENCY-1];
`ifdef HDLC_MON_STRICT_EN
        flagErr  = flagDue ? !Rx_FlagDetect : Rx_FlagDetect;
`else
        flagErr  = flagDue && !Rx_FlagDetect;
`endif
        abortErr = abortVld_p1 && !Rx_AbortSignal;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sr_p0       <= IDLE;
            fill_p0     <= '0;
            state_p0    <= ST_HUNT;
            flagVld_p   <= '0;
            abortVld_p1 <= 1'b0;
            FrameCnt    <= '0;
            Err_Flag    <= 1'b0;
            Err_Abort   <= 1'b0;
        end else begin
            sr_p0    <= srNext;
            fill_p0  <= fillNext;
            state_p0 <= nextState(state_p0, isFlag, isAbort, isIdle);
            if (isFlag && (state_p0 == ST_FRAME)) begin
                FrameCnt <= FrameCnt + 8'd1;
            end
            // Each flag rides its own slot, so closely spaced flags are checked independently.
            flagVld_p[0] <= isFlag;
            for (int k = 1; k < FLAG_LATENCY; k++) begin
                flagVld_p[k] <= flagVld_p[k-1];
            end
            abortVld_p1 <= Rx_ValidFrame && Rx_AbortDetect;
            Err_Flag    <= flagErr;
            Err_Abort   <= abortErr;
        end
    end

    assign ChState = state_p0;

endmodule

// File: rtl/hdlc_rx_monitor.sv
// Multi-lane HDLC Rx checker: one hdlc_mon_chan per lane plus a shared saturating error counter.
// Optional build macro HDLC_MON_STRICT_EN (see hdlc_mon_chan) also reports spurious flag strobes.
module hdlc_rx_monitor
    import hdlc_mon_pkg::*;
#(
    parameter int CHANNELS     = 1,
    parameter int FLAG_LATENCY = 2,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [CHANNELS-1:0]   Rx,
    input  logic [CHANNELS-1:0]   Rx_FlagDetect,
    input  logic [CHANNELS-1:0]   Rx_AbortDetect,
    input  logic [CHANNELS-1:0]   Rx_ValidFrame,
    input  logic [CHANNELS-1:0]   Rx_AbortSignal,
    input  logic                  ErrClr,
    output logic [2*CHANNELS-1:0] ChState,
    output logic [CHANNELS-1:0]   Err_Flag,
    output logic [CHANNELS-1:0]   Err_Abort,
    output logic [8*CHANNELS-1:0] FrameCnt,
    output logic [ERR_CNT_W-1:0]  ErrCnt
);

    localparam int POP_W = $clog2(2*CHANNELS + 1);
    localparam int SUM_W = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-ERR_CNT_W){1'b0}}, {ERR_CNT_W{1'b1}}};

    if ((CHANNELS < 1) || (CHANNELS > 8)) begin : gBadChannels
        $error("hdlc_rx_monitor: CHANNELS must be 1..8");
    end
    if ((FLAG_LATENCY < 1) || (FLAG_LATENCY > 7)) begin : gBadLatency
        $error("hdlc_rx_monitor: FLAG_LATENCY must be 1..7");
    end
    if (ERR_CNT_W < 1) begin : gBadCntW
        $error("hdlc_rx_monitor: ERR_CNT_W must be at least 1");
    end

    function automatic logic [POP_W-1:0] popCount(input logic [2*CHANNELS-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < 2*CHANNELS; k++) begin
            cnt = cnt + POP_W'(v[k]);
        end
        return cnt;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] satLoad(input logic [SUM_W-1:0] s);
        return (s > CNT_MAX) ? CNT_MAX[ERR_CNT_W-1:0] : s[ERR_CNT_W-1:0];
    endfunction

    logic [POP_W-1:0] errPop;

    for (genvar i = 0; i < CHANNELS; i++) begin : gLane
        hdlc_mon_chan #(
            .FLAG_LATENCY(FLAG_LATENCY)
        ) uChan (
            .Clk           (Clk),
            .Rst           (Rst),
            .Rx            (Rx[i]),
            .Rx_FlagDetect (Rx_FlagDetect[i]),
            .Rx_AbortDetect(Rx_AbortDetect[i]),
            .Rx_ValidFrame (Rx_ValidFrame[i]),
            .Rx_AbortSignal(Rx_AbortSignal[i]),
            .ChState       (ChState[2*i+1:2*i]),
            .Err_Flag      (Err_Flag[i]),
            .Err_Abort     (Err_Abort[i]),
            .FrameCnt      (FrameCnt[8*i+7:8*i])
        );
    end

    assign errPop = popCount({Err_Abort, Err_Flag});

    // A clear still counts the errors landing in the same cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ErrCnt <= '0;
        end else if (ErrClr) begin
            ErrCnt <= satLoad(SUM_W'(errPop));
        end else begin
            ErrCnt <= satLoad(SUM_W'(ErrCnt) + SUM_W'(errPop));
        end
    end

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Scoreboard bench for hdlc_rx_monitor: 4 lanes, plus a 2-bit ErrCnt copy for saturation.
module tb_hdlc_rx_monitor;

    localparam int CH  = 4;
    localparam int LAT = 2;

    typedef struct {
        int cyc;
        int lane;
        bit isAbort;
    } exp_t;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic [CH-1:0]   Rx;
    logic [CH-1:0]   Rx_FlagDetect;
    logic [CH-1:0]   Rx_AbortDetect;
    logic [CH-1:0]   Rx_ValidFrame;
    logic [CH-1:0]   Rx_AbortSignal;
    logic            ErrClr;
    logic [2*CH-1:0] ChState, ChStateS;
    logic [CH-1:0]   Err_Flag, Err_Abort, Err_FlagS, Err_AbortS;
    logic [8*CH-1:0] FrameCnt, FrameCntS;
    logic [15:0]     ErrCnt;
    logic [1:0]      ErrCntS;

    logic [CH-1:0] rxV = '1, adV = '0, vfV = '0, asV = '0;
    logic          clrV = 1'b0;
    logic [CH-1:0] fdPlan [int];
    exp_t          expQ [$];
    int            cyc = 0;
    int            nTests = 0;
    int            nFails = 0;

    hdlc_rx_monitor #(.CHANNELS(CH), .FLAG_LATENCY(LAT), .ERR_CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_AbortSignal(Rx_AbortSignal), .ErrClr(ErrClr), .ChState(ChState),
        .Err_Flag(Err_Flag), .Err_Abort(Err_Abort), .FrameCnt(FrameCnt), .ErrCnt(ErrCnt)
    );

    hdlc_rx_monitor #(.CHANNELS(CH), .FLAG_LATENCY(LAT), .ERR_CNT_W(2)) dutSmall (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_AbortSignal(Rx_AbortSignal), .ErrClr(ErrClr), .ChState(ChStateS),
        .Err_Flag(Err_FlagS), .Err_Abort(Err_AbortS), .FrameCnt(FrameCntS), .ErrCnt(ErrCntS)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nTests++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        Rx             = rxV;
        Rx_FlagDetect  = fdPlan.exists(cyc) ? fdPlan[cyc] : 4'h0;
        Rx_AbortDetect = adV;
        Rx_ValidFrame  = vfV;
        Rx_AbortSignal = asV;
        ErrClr         = clrV;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxV = '1;
        repeat (n) tick();
    endtask

    task automatic sendBits(input logic [7:0] b, input logic [CH-1:0] lanes);
        for (int i = 7; i >= 0; i--) begin
            rxV = b[i] ? 4'hF : ~lanes;
            tick();
        end
        rxV = '1;
    endtask

    // Sends 7E on the masked lanes; det chooses which lanes see Rx_FlagDetect LAT cycles later.
    task automatic sendFlag(input logic [CH-1:0] lanes, input logic [CH-1:0] det,
                            input bit pushErr, output int tLast);
        logic [7:0] pat;
        pat = 8'h7E;
        tLast = 0;
        for (int i = 7; i >= 0; i--) begin
            rxV = pat[i] ? 4'hF : ~lanes;
            if (i == 0) begin
                tLast = cyc;
                fdPlan[cyc + LAT] = (fdPlan.exists(cyc + LAT) ? fdPlan[cyc + LAT] : 4'h0) | det;
                if (pushErr) begin
                    for (int ln = 0; ln < CH; ln++) begin
                        if (lanes[ln] && !det[ln]) expQ.push_back('{cyc: cyc + LAT + 1, lane: ln, isAbort: 1'b0});
                    end
                end
            end
            tick();
        end
        rxV = '1;
    endtask

    initial begin : monitor
        logic hit;
        int   idx;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                for (int ln = 0; ln < CH; ln++) begin
                    for (int kd = 0; kd < 2; kd++) begin
                        hit = (kd == 1) ? Err_Abort[ln] : Err_Flag[ln];
                        if (hit) begin
                            idx = -1;
                            for (int k = 0; k < expQ.size(); k++) begin
                                if (idx < 0 && expQ[k].lane == ln && expQ[k].isAbort == (kd == 1)) idx = k;
                            end
                            nTests++;
                            if (idx < 0) begin
                                nFails++;
                                $display("FAIL err_%s lane %0d: pulse at cycle %0d, required none",
                                         (kd == 1) ? "abort" : "flag", ln, cyc);
                            end else begin
                                if (expQ[idx].cyc != cyc) begin
                                    nFails++;
                                    $display("FAIL err_%s lane %0d: pulse at cycle %0d, required at cycle %0d",
                                             (kd == 1) ? "abort" : "flag", ln, cyc, expQ[idx].cyc);
                                end
                                expQ.delete(idx);
                            end
                        end
                    end
                end
                for (int k = expQ.size() - 1; k >= 0; k--) begin
                    if (expQ[k].cyc < cyc) begin
                        nTests++;
                        nFails++;
                        $display("FAIL err_%s lane %0d: no pulse seen, required at cycle %0d",
                                 expQ[k].isAbort ? "abort" : "flag", expQ[k].lane, expQ[k].cyc);
                        expQ.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        Rx = '1; Rx_FlagDetect = '0; Rx_AbortDetect = '0; Rx_ValidFrame = '0;
        Rx_AbortSignal = '0; ErrClr = 1'b0;
        Rst = 1'b1;
        repeat (3) tick();
        check("reset_chstate", 32'(ChState), 32'h0);
        check("reset_framecnt", FrameCnt, 32'h0);
        check("reset_errcnt", 32'(ErrCnt), 32'h0);
        check("reset_errflag", 32'(Err_Flag), 32'h0);
        check("reset_errabort", 32'(Err_Abort), 32'h0);
        Rst = 1'b0;

        // Eight ones take every lane to IDLE.
        idle(8);
        check("idle_all_lanes", 32'(ChState), 32'h55);

        // Flag with a timely detect, one frame, then an abort.
        sendFlag(4'h1, 4'h1, 1'b1, t);
        check("flag_to_frame", 32'(ChState[1:0]), 32'h2);
        sendBits(8'hA5, 4'h1);
        sendBits(8'hC3, 4'h1);
        sendFlag(4'h1, 4'h1, 1'b1, t);
        check("frame_closed_cnt", 32'(FrameCnt[7:0]), 32'h1);
        check("closing_flag_state", 32'(ChState[1:0]), 32'h2);
        sendBits(8'h7F, 4'h1);
        check("abort_to_hunt", 32'(ChState[1:0]), 32'h0);
        idle(10);
        check("good_flags_no_err", 32'(ErrCnt), 32'h0);

        // Missed flag detect on lane 1.
        sendFlag(4'h2, 4'h0, 1'b1, t);
        check("lane1_frame", 32'(ChState[3:2]), 32'h2);
        idle(10);
        check("missed_flag_errcnt", 32'(ErrCnt), 32'h1);

        // Abort: lane 2 misses Rx_AbortSignal, lane 3 gets it.
        expQ.push_back('{cyc: cyc + 2, lane: 2, isAbort: 1'b1});
        rxV = '1; vfV = 4'hC; adV = 4'hC; asV = '0;
        tick();
        adV = '0; asV = 4'h8;
        tick();
        vfV = '0; asV = '0;
        idle(4);
        check("abort_errcnt", 32'(ErrCnt), 32'h2);
        check("abort_errcnt_small", 32'(ErrCntS), 32'h2);

        // All four lanes miss in the same cycle.
        sendFlag(4'hF, 4'h0, 1'b1, t);
        idle(10);
        check("all_lanes_errcnt", 32'(ErrCnt), 32'h6);
        check("small_saturates", 32'(ErrCntS), 32'h3);

        // Back-to-back flags on lane 0: first detected, second missed.
        sendFlag(4'h1, 4'h1, 1'b1, t);
        sendFlag(4'h1, 4'h0, 1'b1, t);
        idle(10);
        check("b2b_framecnt0", 32'(FrameCnt[7:0]), 32'h2);
        check("b2b_framecnt1", 32'(FrameCnt[15:8]), 32'h0);
        check("b2b_errcnt", 32'(ErrCnt), 32'h7);
        check("b2b_small_sat", 32'(ErrCntS), 32'h3);

        // ErrClr coinciding with an error pulse keeps that error.
        sendFlag(4'h1, 4'h0, 1'b1, t);
        while (cyc < t + LAT + 1) tick();
        check("pre_clear_errcnt", 32'(ErrCnt), 32'h7);
        clrV = 1'b1;
        tick();
        clrV = 1'b0;
        check("clear_keeps_err", 32'(ErrCnt), 32'h1);
        check("clear_keeps_err_small", 32'(ErrCntS), 32'h1);
        idle(6);

        // Spurious flag strobe on lane 3.
        fdPlan[cyc] = 4'h8;
`ifdef HDLC_MON_STRICT_EN
        expQ.push_back('{cyc: cyc + 1, lane: 3, isAbort: 1'b0});
`endif
        tick();
        idle(4);
`ifdef HDLC_MON_STRICT_EN
        check("spurious_strobe", 32'(ErrCnt), 32'h2);
`else
        check("spurious_strobe", 32'(ErrCnt), 32'h1);
`endif

        // Reset one cycle before a due check discards it.
        sendFlag(4'h1, 4'h0, 1'b0, t);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("post_reset_errcnt", 32'(ErrCnt), 32'h0);
        sendBits(8'hFE, 4'h1);
        check("no_false_flag_state", 32'(ChState), 32'h54);
        idle(6);
        check("post_reset_framecnt", FrameCnt, 32'h0);
        check("post_reset_errs", 32'(ErrCnt), 32'h0);

        idle(4);
        check("scoreboard_empty", 32'(expQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
